// File: rtl/cell3_exerciser.sv
// ============================================================================
// Module   : cell3_exerciser
// Purpose  : Drives all 8 vectors onto a 3-input cell and checks y against
//            EXP_TABLE. Optional macro CELL3_STOP_ON_FAIL_EN stops at first miss.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cell3_exerciser #(
  parameter int           SETTLE_CYCLES = 2,
  parameter logic [7:0]   EXP_TABLE     = 8'b0111_1111
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] fail_vec
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_settle = 2'd1;
  localparam logic [1:0] c_st_check  = 2'd2;
  localparam logic [1:0] c_st_done   = 2'd3;

  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES - 1);

  logic [1:0] r_state;
  logic [1:0] w_next_state;
  logic [2:0] r_vec;
  logic [3:0] r_cnt;
  logic       w_mismatch;
  logic       w_last;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle:   if (start) w_next_state = c_st_settle;
      c_st_settle: if (r_cnt == 4'd0) w_next_state = c_st_check;
      c_st_check:  w_next_state = w_last ? c_st_done : c_st_settle;
      c_st_done:   w_next_state = c_st_idle;
      default:     w_next_state = c_st_idle;
    endcase
  end

  // Case inequality so that an X or Z on y is reported as a failure.
  always_comb begin
    w_mismatch = (y !== EXP_TABLE[r_vec]);
`ifdef CELL3_STOP_ON_FAIL_EN
    w_last     = (r_vec == 3'd7) || w_mismatch;
`else
    w_last     = (r_vec == 3'd7);
`endif
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_vec     <= 3'd0;
      r_cnt     <= 4'd0;
      {a, b, c} <= 3'b000;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 4'd0;
      fail_vec  <= 3'd0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_vec     <= 3'd0;
            {a, b, c} <= 3'b000;
            err_count <= 4'd0;
            fail_vec  <= 3'd0;
            done      <= 1'b0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            r_cnt     <= c_settle_load;
          end
        end
        c_st_settle: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
        c_st_check: begin
          if (w_mismatch) begin
            err_count <= err_count + 4'd1;
            if (err_count == 4'd0) fail_vec <= r_vec;
          end
          if (!w_last) begin
            r_vec     <= r_vec + 3'd1;
            {a, b, c} <= r_vec + 3'd1;
            r_cnt     <= c_settle_load;
          end
        end
        c_st_done: begin
          done <= 1'b1;
          pass <= (err_count == 4'd0);
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cell3_exerciser.sv
// ============================================================================
// Module   : tb_cell3_exerciser
// Purpose  : Scoreboard bench for cell3_exerciser; cell model selectable per run.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cell3_exerciser;

  localparam int         S   = 2;
  localparam logic [7:0] EXP = 8'b0111_1111;

  typedef struct {
    logic [3:0] errs;
    logic [2:0] fv;
    logic       pass;
    logic [2:0] abc;
    int         lat;
  } res_t;

  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       start = 1'b0;
  logic       y;
  logic       a, b, c, busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] fail_vec;

  logic       start5 = 1'b0;
  logic       y5;
  logic       a5, b5, c5, busy5, done5, pass5;
  logic [3:0] err_count5;
  logic [2:0] fail_vec5;

  int y_mode = 0;
  int errors = 0;
  int checks = 0;

  logic [2:0] vec_q[$];
  res_t       res_q[$];

  always #5 clk = ~clk;

  cell3_exerciser u_dut (
    .clk(clk), .rst_(rst_), .start(start), .y(y),
    .a(a), .b(b), .c(c), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  cell3_exerciser #(.SETTLE_CYCLES(5)) u_dut5 (
    .clk(clk), .rst_(rst_), .start(start5), .y(y5),
    .a(a5), .b(b5), .c(c5), .busy(busy5), .done(done5), .pass(pass5),
    .err_count(err_count5), .fail_vec(fail_vec5)
  );

  always_comb begin
    case (y_mode)
      0:       y = ~(a & b & c);
      1:       y = 1'b1;
      2:       y = 1'b0;
      default: y = 1'bx;
    endcase
  end

  assign y5 = ~(a5 & b5 & c5);

  function automatic logic cell_out(input int mode, input logic [2:0] v);
    case (mode)
      0:       return ~(v[2] & v[1] & v[0]);
      1:       return 1'b1;
      2:       return 1'b0;
      default: return 1'bx;
    endcase
  endfunction

  // Fill the scoreboard for one run of the given cell model.
  task automatic push_expect(input int mode);
    res_t r;
    int   nvec;
    logic yv;
    r.errs = 4'd0;
    r.fv   = 3'd0;
    nvec   = 0;
    for (int v = 0; v < 8; v++) begin
      nvec = v + 1;
      vec_q.push_back(3'(v));
      yv = cell_out(mode, 3'(v));
      if (yv !== EXP[v]) begin
        if (r.errs == 4'd0) r.fv = 3'(v);
        r.errs = r.errs + 4'd1;
`ifdef CELL3_STOP_ON_FAIL_EN
        break;
`endif
      end
    end
    r.pass = (r.errs == 4'd0);
    r.abc  = 3'(nvec - 1);
    r.lat  = nvec * (S + 1) + 1;
    res_q.push_back(r);
  endtask

  task automatic run_case(input string name, input int mode, input int glitch_k);
    int         k;
    bit         seen;
    logic [2:0] ev;
    res_t       r;
    y_mode = mode;
    push_expect(mode);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 0;
    seen = 0;
    while (!seen && k <= 200) begin
      if (k == 0) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL %s accept: busy=%b done=%b, want busy=1 done=0", name, busy, done);
        end
      end
      if ((k % (S + 1)) == 0 && vec_q.size() > 0) begin
        ev = vec_q.pop_front();
        checks++;
        if ({a, b, c} !== ev) begin
          errors++;
          $display("FAIL %s vector@%0d: abc=%b, want %b", name, k, {a, b, c}, ev);
        end
      end
      if (done === 1'b1) begin
        seen = 1;
        r = res_q.pop_front();
        checks++;
        if (k != r.lat) begin
          errors++;
          $display("FAIL %s latency: got %0d edges, want %0d", name, k, r.lat);
        end
        checks++;
        if (err_count !== r.errs || fail_vec !== r.fv || pass !== r.pass) begin
          errors++;
          $display("FAIL %s result: err=%0d fv=%0d pass=%b, want err=%0d fv=%0d pass=%b",
                   name, err_count, fail_vec, pass, r.errs, r.fv, r.pass);
        end
        checks++;
        if (busy !== 1'b0 || {a, b, c} !== r.abc || vec_q.size() != 0) begin
          errors++;
          $display("FAIL %s end: busy=%b abc=%b left=%0d, want busy=0 abc=%b left=0",
                   name, busy, {a, b, c}, vec_q.size(), r.abc);
        end
      end else begin
        if (k + 1 == glitch_k) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k++;
      end
    end
    if (!seen) begin
      errors++;
      checks++;
      $display("FAIL %s timeout: done=%b after %0d edges, want done=1", name, done, k);
      vec_q.delete();
      res_q.delete();
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({a, b, c, busy, done, pass, err_count, fail_vec} !== 13'd0) begin
      errors++;
      $display("FAIL reset: outs=%b, want all 0", {a, b, c, busy, done, pass, err_count, fail_vec});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic test_reset_mid_run();
    y_mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4 * (S + 1) + 1) @(posedge clk);
    #2;
    checks++;
    if ({a, b, c} !== 3'b100 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrun pre-reset: abc=%b busy=%b, want 100 1", {a, b, c}, busy);
    end
    rst_ = 1'b0;
    #1;
    checks++;
    if ({a, b, c, busy, done, pass, err_count, fail_vec} !== 13'd0) begin
      errors++;
      $display("FAIL midrun reset: outs=%b, want all 0", {a, b, c, busy, done, pass, err_count, fail_vec});
    end
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun no-done: done=%b busy=%b, want 0 0", done, busy);
    end
    run_case("after_reset", 0, 0);
  endtask

  task automatic test_settle5();
    int k;
    @(negedge clk);
    start5 = 1'b1;
    @(posedge clk);
    #1;
    start5 = 1'b0;
    k = 0;
    while (done5 !== 1'b1 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    checks++;
    if (k != 49) begin
      errors++;
      $display("FAIL settle5 latency: got %0d edges, want 49", k);
    end
    checks++;
    if (pass5 !== 1'b1 || err_count5 !== 4'd0 || fail_vec5 !== 3'd0 || busy5 !== 1'b0) begin
      errors++;
      $display("FAIL settle5 result: pass=%b err=%0d fv=%0d busy=%b, want 1 0 0 0",
               pass5, err_count5, fail_vec5, busy5);
    end
  endtask

  initial begin
    test_reset();
    run_case("nd3", 0, 0);
    run_case("tied1", 1, 0);
    run_case("tied0", 2, 0);
    run_case("x_in", 3, 0);
    run_case("busy_start", 0, 10);
    run_case("back_to_back", 0, 0);
    test_reset_mid_run();
    test_settle5();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
